// File: rtl/multi_cycle_control.sv
// multi_cycle_control: FSM sequencer for a multi-cycle MIPS datapath.
// Issues per-state mux selects and write enables, stalls on mem_ready,
// halts on an unsupported opcode and counts completed instruction fetches.
// Ports:
//   clk, rstn          clock, async active-low reset
//   opcode [5:0]       IR[31:26], valid from DECODE onward
//   mem_ready          memory access completes this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//   alu_op[1:0], pc_source[1:0]   datapath controls
//   halted             unsupported opcode seen
//   state [3:0]        current state (debug)
//   instr_count [31:0] completed fetches, wraps
module multi_cycle_control (
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        halted,
  output logic [3:0]  state,
  output logic [31:0] instr_count
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] S_RESET     = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_ADDI_EX   = 4'd11;
  localparam logic [3:0] S_ADDI_WB   = 4'd12;
  localparam logic [3:0] S_HALT      = 4'd13;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // State and fetch-counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_RESET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A fetch completes on the mem_ready cycle of FETCH; counter wraps naturally
  always_comb begin
    count_d = count_q;
    if (state_q == S_FETCH && mem_ready) count_d = count_q + CNT_W'(1);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:     state_d = S_FETCH;
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_HALT;
        endcase
      end
      // IR is stable, so the opcode is simply re-read to pick load or store
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_RESET;
    endcase
  end

  // Moore control decode; only FETCH ir_write/pc_write see mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    halted        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:   reg_write = 1'b1;
      S_HALT:      halted = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: directed plus randomized checks of multi_cycle_control
// against a per-instruction cycle model built from the opcode and wait counts.
module tb_multi_cycle_control;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multi_cycle_control dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .halted(halted), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADDR = 3,
                 ST_MEM_READ = 4, ST_MEM_WB = 5, ST_MEM_WRITE = 6, ST_R_EXEC = 7,
                 ST_R_WB = 8, ST_BRANCH = 9, ST_JUMP = 10, ST_ADDI_EX = 11,
                 ST_ADDI_WB = 12, ST_HALT = 13;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_count = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control word the spec assigns to each state (unlisted outputs are 0)
  function automatic logic [16:0] exp_outs(input int st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, h;
    logic [1:0] asb, aop, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, h} = '0;
    asb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      ST_FETCH:     begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      ST_DECODE:    asb = 2'b11;
      ST_MEM_ADDR:  begin asa = 1; asb = 2'b10; end
      ST_MEM_READ:  begin mr = 1; iod = 1; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; end
      ST_MEM_WRITE: begin mw = 1; iod = 1; end
      ST_R_EXEC:    begin asa = 1; aop = 2'b10; end
      ST_R_WB:      begin rd = 1; rw = 1; end
      ST_BRANCH:    begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      ST_JUMP:      begin pw = 1; ps = 2'b10; end
      ST_ADDI_EX:   begin asa = 1; asb = 2'b10; end
      ST_ADDI_WB:   rw = 1;
      ST_HALT:      h = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps, h};
  endfunction

  function automatic logic [16:0] obs_outs();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, halted};
  endfunction

  // One clock cycle: drive mem_ready mid-low-phase, check, then let the edge pass
  task automatic step(input int exp_st, input logic rdy, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    chk({tag, "_state"}, 32'(state), 32'(exp_st));
    chk({tag, "_outs"}, 32'(obs_outs()), 32'(exp_outs(exp_st, rdy)));
    chk({tag, "_count"}, instr_count, model_count);
    chk({tag, "_pcw_excl"}, 32'(pc_write & pc_write_cond), 32'd0);
    chk({tag, "_mem_excl"}, 32'(mem_read & mem_write), 32'd0);
    if (exp_st == ST_FETCH && rdy) model_count = model_count + 32'd1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    chk("rst_state", 32'(state), 32'(ST_RESET));
    chk("rst_outs", 32'(obs_outs()), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    model_count = 0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_rel_state", 32'(state), 32'(ST_RESET));
    chk("rst_rel_outs", 32'(obs_outs()), 32'd0);
  endtask

  // Full instruction: fw FETCH waits, mw memory waits; non-wait states get random mem_ready
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int halt_cycles);
    int base, cpi;
    base = cyc;
    opcode = op;
    for (int i = 0; i < fw; i++) step(ST_FETCH, 1'b0, "fetch_wait");
    step(ST_FETCH, 1'b1, "fetch");
    step(ST_DECODE, 1'($urandom), "decode");
    case (op)
      6'h23: begin
        step(ST_MEM_ADDR, 1'($urandom), "lw_addr");
        for (int i = 0; i < mw; i++) step(ST_MEM_READ, 1'b0, "lw_wait");
        step(ST_MEM_READ, 1'b1, "lw_read");
        step(ST_MEM_WB, 1'($urandom), "lw_wb");
        cpi = 5;
      end
      6'h2B: begin
        step(ST_MEM_ADDR, 1'($urandom), "sw_addr");
        for (int i = 0; i < mw; i++) step(ST_MEM_WRITE, 1'b0, "sw_wait");
        step(ST_MEM_WRITE, 1'b1, "sw_write");
        cpi = 4;
      end
      6'h00: begin
        step(ST_R_EXEC, 1'($urandom), "r_exec");
        step(ST_R_WB, 1'($urandom), "r_wb");
        cpi = 4;
      end
      6'h08: begin
        step(ST_ADDI_EX, 1'($urandom), "addi_ex");
        step(ST_ADDI_WB, 1'($urandom), "addi_wb");
        cpi = 4;
      end
      6'h04: begin step(ST_BRANCH, 1'($urandom), "beq"); cpi = 3; end
      6'h02: begin step(ST_JUMP, 1'($urandom), "jump"); cpi = 3; end
      default: begin
        for (int i = 0; i < halt_cycles; i++) step(ST_HALT, 1'($urandom), "halt");
        cpi = 2 + halt_cycles;
      end
    endcase
    if (op == 6'h23 || op == 6'h2B) cpi = cpi + mw;
    chk("cycles_per_instr", 32'(cyc - base), 32'(cpi + fw));
  endtask

  logic [5:0] ops [6];
  logic [5:0] bad;

  initial begin
    ops[0] = 6'h00; ops[1] = 6'h02; ops[2] = 6'h04;
    ops[3] = 6'h08; ops[4] = 6'h23; ops[5] = 6'h2B;

    // Async reset while clock runs
    do_reset();

    // lw with no waits, then sw with 3 store waits
    run_instr(6'h23, 0, 0, 0);
    run_instr(6'h2B, 0, 3, 0);

    // R-type, beq, j back-to-back
    run_instr(6'h00, 0, 0, 0);
    run_instr(6'h04, 0, 0, 0);
    run_instr(6'h02, 0, 0, 0);
    chk("count_after_five", instr_count, 32'd5);

    // FETCH stall of 2 cycles then addi
    run_instr(6'h08, 2, 0, 0);

    // Unsupported opcode halts; reset recovers
    run_instr(6'h3F, 0, 0, 20);
    do_reset();

    // Reset asserted during a MEM_READ wait aborts the load at once
    opcode = 6'h23;
    step(ST_FETCH, 1'b1, "abort_fetch");
    step(ST_DECODE, 1'b1, "abort_decode");
    step(ST_MEM_ADDR, 1'b1, "abort_addr");
    step(ST_MEM_READ, 1'b0, "abort_read");
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'(ST_RESET));
    chk("abort_outs", 32'(obs_outs()), 32'd0);
    chk("abort_count", instr_count, 32'd0);
    model_count = 0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("abort_rel_state", 32'(state), 32'(ST_RESET));
    run_instr(6'h23, 1, 1, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                $urandom_range(0, 3), 0);
    end

    // Random unsupported opcode ends the stream in HALT
    do begin
      bad = 6'($urandom);
    end while (bad == 6'h00 || bad == 6'h02 || bad == 6'h04 ||
               bad == 6'h08 || bad == 6'h23 || bad == 6'h2B);
    run_instr(bad, $urandom_range(0, 2), 0, 8);
    do_reset();
    run_instr(6'h04, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
